// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the sysid slave.
interface sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and latches whether
// they match the build-time values; runs after reset (AUTO_START) or on start.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1445131627,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    sysid_checker_if.master        avm,
    output logic                   busy,
    output logic                   done,
    output logic                   id_match,
    output logic                   ts_match,
    output logic                   timeout,
    output logic [31:0]            id_value,
    output logic [31:0]            ts_value
);
    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        first;
    logic        launch;
    logic        stalled;

    // first is only high on the cycle right after reset, so AUTO_START fires once
    assign launch  = ((state == IDLE) && ((AUTO_START && first) || start)) ||
                     ((state == DONE) && start);
    assign stalled = avm.avm_waitrequest;

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            avm.avm_read    <= 1'b0;
            avm.avm_address <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            id_match        <= 1'b0;
            ts_match        <= 1'b0;
            timeout         <= 1'b0;
            id_value        <= 32'd0;
            ts_value        <= 32'd0;
            wait_cnt        <= 16'd0;
            first           <= 1'b1;
        end else begin
            first <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        state           <= RD_ID;
                        avm.avm_read    <= 1'b1;
                        avm.avm_address <= 1'b0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        id_match        <= 1'b0;
                        ts_match        <= 1'b0;
                        timeout         <= 1'b0;
                        wait_cnt        <= 16'd0;
                    end
                end
                RD_ID: begin
                    if (!stalled) begin
                        id_value        <= avm.avm_readdata;
                        id_match        <= (avm.avm_readdata == EXPECTED_ID);
                        wait_cnt        <= 16'd0;
                        avm.avm_address <= 1'b1;
                        state           <= RD_TS;
                    end else if (wait_cnt == TMO) begin
                        // abandon the check; the TS read is skipped entirely
                        timeout         <= 1'b1;
                        avm.avm_read    <= 1'b0;
                        avm.avm_address <= 1'b0;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        state           <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RD_TS: begin
                    if (!stalled) begin
                        ts_value        <= avm.avm_readdata;
                        ts_match        <= (avm.avm_readdata == EXPECTED_TS);
                        avm.avm_read    <= 1'b0;
                        avm.avm_address <= 1'b0;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        state           <= DONE;
                    end else if (wait_cnt == TMO) begin
                        timeout         <= 1'b1;
                        avm.avm_read    <= 1'b0;
                        avm.avm_address <= 1'b0;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        state           <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sysid_checker.sv
// Three checker instances (auto-start, manual-start, stuck slave) against a
// directed slave model; expected results are queued and popped on done rising.
module tb_sysid_checker;
    localparam logic [31:0] TS = 32'd1445131627;

    typedef struct {
        int          inst;
        int          cyc;
        logic        idm;
        logic        tsm;
        logic        to;
        logic [31:0] idv;
        logic [31:0] tsv;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst[3];
    logic        st[3];
    logic [31:0] id_w[3];
    logic [31:0] ts_w[3];
    int          sid[3];
    int          sts[3];

    logic        bz[3], dn[3], idm[3], tsm[3], tmo[3];
    logic [31:0] idv[3], tsv[3];
    logic        rd[3], ad[3], wr[3];

    logic        s_rd[3], s_ad[3], s_wr[3], s_rst[3], p_dn[3];
    int          dcnt[3];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        exp_q[$];

    sysid_checker_if bus_a();
    sysid_checker_if bus_b();
    sysid_checker_if bus_c();

    assign bus_a.avm_readdata    = bus_a.avm_address ? ts_w[0] : id_w[0];
    assign bus_a.avm_waitrequest = bus_a.avm_read && (bus_a.avm_address ? (sts[0] != 0) : (sid[0] != 0));
    assign bus_b.avm_readdata    = bus_b.avm_address ? ts_w[1] : id_w[1];
    assign bus_b.avm_waitrequest = bus_b.avm_read && (bus_b.avm_address ? (sts[1] != 0) : (sid[1] != 0));
    assign bus_c.avm_readdata    = bus_c.avm_address ? ts_w[2] : id_w[2];
    assign bus_c.avm_waitrequest = 1'b1;

    assign rd[0] = bus_a.avm_read;  assign ad[0] = bus_a.avm_address;  assign wr[0] = bus_a.avm_waitrequest;
    assign rd[1] = bus_b.avm_read;  assign ad[1] = bus_b.avm_address;  assign wr[1] = bus_b.avm_waitrequest;
    assign rd[2] = bus_c.avm_read;  assign ad[2] = bus_c.avm_address;  assign wr[2] = bus_c.avm_waitrequest;

    sysid_checker #(.TIMEOUT_CYCLES(255), .AUTO_START(1'b1)) dut_a (
        .clock(clock), .reset(rst[0]), .start(st[0]), .avm(bus_a.master),
        .busy(bz[0]), .done(dn[0]), .id_match(idm[0]), .ts_match(tsm[0]),
        .timeout(tmo[0]), .id_value(idv[0]), .ts_value(tsv[0]));

    sysid_checker #(.TIMEOUT_CYCLES(4), .AUTO_START(1'b0)) dut_b (
        .clock(clock), .reset(rst[1]), .start(st[1]), .avm(bus_b.master),
        .busy(bz[1]), .done(dn[1]), .id_match(idm[1]), .ts_match(tsm[1]),
        .timeout(tmo[1]), .id_value(idv[1]), .ts_value(tsv[1]));

    sysid_checker #(.TIMEOUT_CYCLES(4), .AUTO_START(1'b1)) dut_c (
        .clock(clock), .reset(rst[2]), .start(st[2]), .avm(bus_c.master),
        .busy(bz[2]), .done(dn[2]), .id_match(idm[2]), .ts_match(tsm[2]),
        .timeout(tmo[2]), .id_value(idv[2]), .ts_value(tsv[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic push(input int inst, input int dly, input logic im, input logic tm,
                        input logic to, input logic [31:0] iv, input logic [31:0] tv);
        exp_t e;
        e.inst = inst; e.cyc = cyc + dly; e.idm = im; e.tsm = tm;
        e.to = to; e.idv = iv; e.tsv = tv;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // what the DUT saw at the edge: DUT regs update in NBA, so these are pre-edge values
    always @(posedge clock) begin
        cyc = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            s_rd[i]  = rd[i];
            s_ad[i]  = ad[i];
            s_wr[i]  = wr[i];
            s_rst[i] = rst[i];
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (s_rd[i] && s_wr[i] && !s_rst[i]) begin
                if (!dn[i]) begin
                    chk("stall_read_held", rd[i], 1);
                    chk("stall_addr_held", ad[i], s_ad[i]);
                end
                if (s_ad[i]) begin
                    if (sts[i] > 0) sts[i]--;
                end else if (sid[i] > 0) sid[i]--;
            end
            if (dn[i] && !p_dn[i]) begin
                dcnt[i]++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: instance %0d at cycle %0d, none required", i, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_instance", i, e.inst);
                    chk("done_cycle", cyc, e.cyc);
                    chk("id_match", idm[i], e.idm);
                    chk("ts_match", tsm[i], e.tsm);
                    chk("timeout", tmo[i], e.to);
                    chk("id_value", idv[i], e.idv);
                    chk("ts_value", tsv[i], e.tsv);
                    chk("read_low_at_done", rd[i], 0);
                    chk("busy_low_at_done", bz[i], 0);
                end
            end
            p_dn[i] = dn[i];
        end
    end

    initial begin
        bit found;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; st[i] = 1'b0; id_w[i] = 32'd0; ts_w[i] = TS;
            sid[i] = 0; sts[i] = 0; dcnt[i] = 0; p_dn[i] = 1'b0;
            s_rd[i] = 1'b0; s_ad[i] = 1'b0; s_wr[i] = 1'b0; s_rst[i] = 1'b1;
        end
        tick(3);

        chk("rst_busy", bz[0], 0);
        chk("rst_done", dn[0], 0);
        chk("rst_read", rd[0], 0);
        chk("rst_addr", ad[0], 0);
        chk("rst_timeout", tmo[0], 0);
        chk("rst_id_match", idm[0], 0);
        chk("rst_ts_match", tsm[0], 0);
        chk("rst_id_value", idv[0], 0);
        chk("rst_ts_value", tsv[0], 0);

        // auto-start, zero waits
        push(0, 3, 1, 1, 0, 32'd0, TS);
        rst[0] = 1'b0;
        drain(20);

        // restart from DONE with a wrong timestamp
        ts_w[0] = 32'h0000_0001;
        push(0, 3, 1, 0, 0, 32'd0, 32'd1);
        st[0] = 1'b1;
        tick(1);
        st[0] = 1'b0;
        chk("restart_done_low", dn[0], 0);
        chk("restart_busy_high", bz[0], 1);
        drain(20);

        // five waitrequest cycles on the ID read
        ts_w[0] = TS;
        rst[0] = 1'b1;
        tick(2);
        sid[0] = 5;
        push(0, 8, 1, 1, 0, 32'd0, TS);
        rst[0] = 1'b0;
        drain(30);

        // reset while stalled in RD_TS, then a clean rerun
        rst[0] = 1'b1;
        tick(2);
        sts[0] = 50;
        rst[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(1);
            if (rd[0] && ad[0]) found = 1'b1;
        end
        chk("reach_rd_ts", found, 1);
        chk("mid_id_match", idm[0], 1);
        chk("mid_busy", bz[0], 1);
        rst[0] = 1'b1;
        tick(1);
        chk("midrst_read", rd[0], 0);
        chk("midrst_busy", bz[0], 0);
        chk("midrst_done", dn[0], 0);
        chk("midrst_id_match", idm[0], 0);
        chk("midrst_ts_match", tsm[0], 0);
        chk("midrst_timeout", tmo[0], 0);
        sts[0] = 0;
        tick(1);
        push(0, 3, 1, 1, 0, 32'd0, TS);
        rst[0] = 1'b0;
        drain(20);

        // slave stuck in waitrequest, TIMEOUT_CYCLES=4
        push(2, 6, 0, 0, 1, 32'd0, 32'd0);
        rst[2] = 1'b0;
        drain(30);

        // manual start only; a second start while busy is dropped
        rst[1] = 1'b0;
        tick(5);
        chk("noauto_read", rd[1], 0);
        chk("noauto_busy", bz[1], 0);
        chk("noauto_done", dn[1], 0);
        sid[1] = 3;
        push(1, 6, 1, 1, 0, 32'd0, TS);
        st[1] = 1'b1;
        tick(1);
        st[1] = 1'b0;
        tick(1);
        chk("busy_at_second_start", bz[1], 1);
        st[1] = 1'b1;
        tick(1);
        st[1] = 1'b0;
        drain(30);
        tick(20);
        chk("single_done", dcnt[1], 1);

        // reset wins over start on the same edge
        rst[1] = 1'b1;
        st[1]  = 1'b1;
        tick(1);
        st[1] = 1'b0;
        chk("rst_over_start_busy", bz[1], 0);
        chk("rst_over_start_done", dn[1], 0);
        rst[1] = 1'b0;
        tick(5);
        chk("post_rst_no_read", rd[1], 0);
        chk("post_rst_done_count", dcnt[1], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
